// File: rtl/uart_tx_sched_if.sv
// Bundle of the signals between the byte sources, the scheduler and the
// UART transmitter.
// The scheduler connects to the slave modport.
// The master modport is for the environment that raises requests and reports
// transmitter completion.
interface uart_tx_sched_if #(
    parameter int NREQ      = 4,
    parameter int DATA_BITS = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]           req;
    logic [NREQ*DATA_BITS-1:0] req_data;
    logic [NREQ-1:0]           gnt;
    logic [DATA_BITS-1:0]      tx_data;
    logic                      txd_startH;
    logic                      txd_done;
    logic                      busy;
    logic [OW-1:0]             owner;
    logic                      tmo_err;

    modport master (
        output req, req_data, txd_done,
        input  gnt, tx_data, txd_startH, busy, owner, tmo_err
    );

    modport slave (
        input  req, req_data, txd_done,
        output gnt, tx_data, txd_startH, busy, owner, tmo_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter between NREQ byte sources.
// A grant captures the winner's byte and pulses txd_startH.
// The scheduler then waits for a rising edge on txd_done, or aborts after
// TIMEOUT cycles.
// It then holds off for GAP_CYCLES cycles before it arbitrates again.
// All outputs come straight from flops.
module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int DATA_BITS  = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input logic            bclk,
    input logic            rst_n,
    uart_tx_sched_if.slave bus
);

    localparam int OW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [OW-1:0] OWNER_RST = OW'(NREQ - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic                 tmo_err_q, tmo_err_d;
    logic [WW-1:0]        wd_cnt_q, wd_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                 done_q, done_d;

    logic [OW-1:0]        sel;
    logic [OW-1:0]        cand;
    logic                 req_any;
    logic                 done_rise;

    // Only a low-to-high transition of txd_done counts as frame completion.
    // This stops a level left high by the previous frame from ending the next one early.
    assign done_rise = bus.txd_done & ~done_q;

    // Find the requester to serve next.
    // The search starts just after the last owner and wraps around, so every
    // pending requester is served before any one is served twice.
    always_comb begin
        sel     = owner_q;
        cand    = owner_q;
        req_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((int'(owner_q) + k) % NREQ);
            if (!req_any && bus.req[cand]) begin
                req_any = 1'b1;
                sel     = cand;
            end
        end
    end

    // Next-state and registered-output logic for the grant / wait / gap sequence.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        tx_data_d = tx_data_q;
        start_d   = 1'b0;
        owner_d   = owner_q;
        tmo_err_d = 1'b0;
        wd_cnt_d  = wd_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = bus.txd_done;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d[sel] = 1'b1;
                    tx_data_d  = bus.req_data[int'(sel) * DATA_BITS +: DATA_BITS];
                    owner_d    = sel;
                    start_d    = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                wd_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                wd_cnt_d = wd_cnt_q + WW'(1);
                if (done_rise) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (wd_cnt_q == WD_LAST) begin
                    tmo_err_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counter and output registers.
    // Reset returns to IDLE at once, even in the middle of a frame.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            tx_data_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            owner_q   <= OWNER_RST;
            tmo_err_q <= 1'b0;
            wd_cnt_q  <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            tx_data_q <= tx_data_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            tmo_err_q <= tmo_err_d;
            wd_cnt_q  <= wd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.txd_startH = start_q;
    assign bus.busy       = busy_q;
    assign bus.owner      = owner_q;
    assign bus.tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched.
// Stimulus processes push expected grants, timeout pulses and return-to-idle
// cycles into queues.
// A monitor pops and compares those entries whenever the DUT shows the
// matching event.
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int DB   = 8;
    localparam int GAPC = 2;
    localparam int TMO  = 64;
    localparam int OW   = $clog2(NREQ);

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_STALE  = 2;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        logic [DB-1:0]   data;
        int              owner;
    } exp_t;

    logic bclk;
    logic rst_n;
    int   cyc;

    int tests_run;
    int tests_failed;

    exp_t gq[$];
    int   tq[$];
    int   fq[$];

    logic [DB-1:0] data_arr[NREQ];
    int            model_owner;

    int tx_mode;
    int tx_delay;

    uart_tx_sched_if #(.NREQ(NREQ), .DATA_BITS(DB)) bus ();

    uart_tx_sched #(
        .NREQ      (NREQ),
        .DATA_BITS (DB),
        .GAP_CYCLES(GAPC),
        .TIMEOUT   (TMO)
    ) dut (
        .bclk (bclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock.
    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    // Bench cycle counter that all expected timings refer to.
    initial cyc = 0;
    always @(posedge bclk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name, input int act);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s @cyc %0d: got %0d, expected no event", name, cyc, act);
    endtask

    // Reference arbitration rule.
    // Take the first set request bit found at last+1, last+2, ... modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Must be called at a falling edge; returns at the falling edge where cyc == t.
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge bclk);
    endtask

    task automatic set_data(input int i, input logic [DB-1:0] v);
        data_arr[i] = v;
        bus.req_data[i*DB +: DB] = v;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) set_data(i, DB'($urandom));
    endtask

    // Issue a burst of requests.
    // Expected grants and completion timings come from the reference rules.
    // The first frame uses the given transmitter behaviour; later frames
    // complete after a random delay.
    task automatic apply_stimulus(input logic [NREQ-1:0] r, input bit hold, input int nframes_in,
                                  input int first_mode, input int first_delay);
        logic [NREQ-1:0] pend;
        int g, w, mode, d, fall, nframes;
        exp_t e;
        pend    = r;
        nframes = hold ? nframes_in : $countones(r);
        g       = cyc + 1;
        fall    = cyc;
        for (int f = 0; f < nframes; f++) begin
            wait_cyc(g - 1);
            if (f == 0) begin
                mode = first_mode;
                d    = first_delay;
            end else begin
                mode = MODE_NORMAL;
                d    = $urandom_range(1, TMO);
            end
            tx_mode  = mode;
            tx_delay = d;
            bus.req  = pend;
            w        = rr_pick(pend, model_owner);
            e.cyc    = g;
            e.gnt    = '0;
            e.gnt[w] = 1'b1;
            e.data   = data_arr[w];
            e.owner  = w;
            gq.push_back(e);
            model_owner = w;
            if (mode == MODE_NEVER) begin
                tq.push_back(g + TMO + 1);
                fall = g + TMO + 1 + GAPC;
            end else if (mode == MODE_STALE) begin
                fall = g + 12 + 1 + GAPC;
            end else begin
                fall = g + d + 1 + GAPC;
            end
            fq.push_back(fall);
            wait_cyc(g);
            if (!hold) pend[w] = 1'b0;
            if (f == nframes - 1) pend = '0;
            bus.req = pend;
            set_data(w, DB'($urandom));
            g = fall + 1;
        end
        wait_cyc(fall);
    endtask

    // Transmitter model.
    // On a start pulse it drops done, then raises it after the requested
    // delay, never, or with the stale-done pattern.
    initial begin : tx_model
        int j, cur_mode, cur_delay;
        bit active;
        active = 1'b0;
        j = 0;
        cur_mode = MODE_NORMAL;
        cur_delay = 1;
        forever begin
            @(negedge bclk);
            if (!rst_n) begin
                bus.txd_done = 1'b1;
                active = 1'b0;
            end else if (bus.txd_startH) begin
                cur_mode  = tx_mode;
                cur_delay = tx_delay;
                j = 0;
                active = (cur_mode != MODE_NEVER);
                if (cur_mode != MODE_STALE) bus.txd_done = 1'b0;
            end else if (active) begin
                j++;
                if (cur_mode == MODE_STALE) begin
                    if (j == 5) bus.txd_done = 1'b0;
                    if (j == 12) begin
                        bus.txd_done = 1'b1;
                        active = 1'b0;
                    end
                end else if (j == cur_delay) begin
                    bus.txd_done = 1'b1;
                    active = 1'b0;
                end
            end
        end
    end

    // Monitor.
    // Shortly after each rising edge, compare grants, timeout pulses and
    // busy-falling (return to IDLE) events against the queues.
    initial begin : monitor
        bit prev_busy;
        exp_t e;
        int t;
        prev_busy = 1'b0;
        forever begin
            @(posedge bclk);
            #1;
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                if (bus.gnt != '0) begin
                    if (gq.size() == 0) begin
                        report_unexpected("gnt", int'(bus.gnt));
                    end else begin
                        e = gq.pop_front();
                        check_output("gnt cycle", cyc, e.cyc);
                        check_output("gnt vector", int'(bus.gnt), int'(e.gnt));
                        check_output("tx_data", int'(bus.tx_data), int'(e.data));
                        check_output("owner", int'(bus.owner), e.owner);
                        check_output("txd_startH with gnt", int'(bus.txd_startH), 1);
                    end
                end else if (bus.txd_startH) begin
                    report_unexpected("txd_startH without gnt", 1);
                end
                if (bus.tmo_err) begin
                    if (tq.size() == 0) begin
                        report_unexpected("tmo_err", 1);
                    end else begin
                        t = tq.pop_front();
                        check_output("tmo_err cycle", cyc, t);
                    end
                end
                if (prev_busy && !bus.busy) begin
                    if (fq.size() == 0) begin
                        report_unexpected("return to idle", cyc);
                    end else begin
                        t = fq.pop_front();
                        check_output("idle cycle", cyc, t);
                    end
                end
                prev_busy = bus.busy;
            end
        end
    end

    // Main sequence of directed scenarios followed by random bursts.
    initial begin : stimulus
        logic [NREQ-1:0] r;
        int w, c;
        tests_run    = 0;
        tests_failed = 0;
        tx_mode      = MODE_NORMAL;
        tx_delay     = 1;
        model_owner  = NREQ - 1;
        rst_n        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.txd_done = 1'b1;
        randomize_data();
        #1 rst_n = 1'b0;
        #2;
        check_output("reset gnt", int'(bus.gnt), 0);
        check_output("reset tx_data", int'(bus.tx_data), 0);
        check_output("reset txd_startH", int'(bus.txd_startH), 0);
        check_output("reset busy", int'(bus.busy), 0);
        check_output("reset owner", int'(bus.owner), NREQ - 1);
        check_output("reset tmo_err", int'(bus.tmo_err), 0);
        @(negedge bclk);
        @(negedge bclk);
        rst_n = 1'b1;

        $display("[TB] round-robin fairness, all requesters held");
        apply_stimulus(4'b1111, 1'b1, 5, MODE_NORMAL, 7);

        $display("[TB] single request, byte 8'hA5");
        set_data(1, 8'hA5);
        apply_stimulus(4'b0010, 1'b0, 1, MODE_NORMAL, 20);

        $display("[TB] priority rotation");
        apply_stimulus(4'b0100, 1'b0, 1, MODE_NORMAL, 3);
        apply_stimulus(4'b0101, 1'b0, 2, MODE_NORMAL, 5);

        $display("[TB] watchdog abort then pending request");
        apply_stimulus(4'b1001, 1'b0, 2, MODE_NEVER, 0);

        $display("[TB] stale done level");
        apply_stimulus(4'b0010, 1'b0, 1, MODE_STALE, 0);

        $display("[TB] done rise coinciding with timeout");
        apply_stimulus(4'b0001, 1'b0, 1, MODE_NORMAL, TMO);

        $display("[TB] reset in WAIT_DONE");
        c        = cyc;
        tx_mode  = MODE_NORMAL;
        tx_delay = 40;
        r        = 4'b0010;
        bus.req  = r;
        w        = rr_pick(r, model_owner);
        gq.push_back('{cyc: c + 1, gnt: 4'b0010, data: data_arr[w], owner: w});
        model_owner = w;
        wait_cyc(c + 1);
        bus.req = '0;
        wait_cyc(c + 6);
        rst_n = 1'b0;
        #1;
        check_output("mid-frame reset gnt", int'(bus.gnt), 0);
        check_output("mid-frame reset tx_data", int'(bus.tx_data), 0);
        check_output("mid-frame reset txd_startH", int'(bus.txd_startH), 0);
        check_output("mid-frame reset busy", int'(bus.busy), 0);
        check_output("mid-frame reset owner", int'(bus.owner), NREQ - 1);
        check_output("mid-frame reset tmo_err", int'(bus.tmo_err), 0);
        model_owner = NREQ - 1;
        @(negedge bclk);
        @(negedge bclk);
        rst_n = 1'b1;
        apply_stimulus(4'b0001, 1'b0, 1, MODE_NORMAL, 9);

        $display("[TB] random bursts");
        for (int n = 0; n < 20; n++) begin
            randomize_data();
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            apply_stimulus(r, 1'b0, 1,
                           ($urandom_range(0, 5) == 0) ? MODE_NEVER : MODE_NORMAL,
                           $urandom_range(1, TMO));
        end

        repeat (5) @(negedge bclk);
        check_output("pending grants", gq.size(), 0);
        check_output("pending timeouts", tq.size(), 0);
        check_output("pending idle returns", fq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
